// File: rtl/comp_pkg.sv
// Shared types and helpers for the multi-word compare/subtract slice.
package comp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_UNSIGNED = 1'b0;
  localparam logic MODE_SIGNED   = 1'b1;

  // Width of the word index register; never narrower than one bit.
  function automatic int idx_width(input int n);
    if (n <= 1) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/multiword_comp_if.sv
// Request/result bundle between a requester and the multi-word comparator.
interface multiword_comp_if #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_WORDS  = 4
);
  localparam int W = DATA_WIDTH * NUM_WORDS;

  logic         start;
  logic         mode_signed;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         borrow_in;
  logic         ready;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow_out;
  logic         lt;
  logic         eq;
  logic         gt;

  modport master (
    output start, mode_signed, a, b, borrow_in,
    input  ready, done, diff, borrow_out, lt, eq, gt
  );

  modport slave (
    input  start, mode_signed, a, b, borrow_in,
    output ready, done, diff, borrow_out, lt, eq, gt
  );

endinterface

// File: rtl/word_sub.sv
// One-word subtractor with borrow chaining and signed-overflow detection.
module word_sub #(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] a_w,
  input  logic [DATA_WIDTH-1:0] b_w,
  input  logic                  borrow_in,
  output logic [DATA_WIDTH-1:0] d_w,
  output logic                  borrow_out,
  output logic                  ovf
);

  logic [DATA_WIDTH:0] full;
  logic                msb_borrow_in;

  // Subtract with one extra bit; overflow is the borrow into the MSB
  // differing from the borrow out of it.
  always_comb begin
    full          = {1'b0, a_w} - {1'b0, b_w} - {{DATA_WIDTH{1'b0}}, borrow_in};
    msb_borrow_in = full[DATA_WIDTH-1] ^ a_w[DATA_WIDTH-1] ^ b_w[DATA_WIDTH-1];
    d_w           = full[DATA_WIDTH-1:0];
    borrow_out    = full[DATA_WIDTH];
    ovf           = msb_borrow_in ^ full[DATA_WIDTH];
  end

endmodule

// File: rtl/multiword_comp.sv
// Sequential wide compare: A - B - borrow_in, one word per clock, LSW first.
module multiword_comp
  import comp_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_WORDS  = 4,
  parameter bit SIGNED_EN  = 1'b1
) (
  input logic             clk,
  input logic             rst_n,
  multiword_comp_if.slave bus
);

  localparam int W     = DATA_WIDTH * NUM_WORDS;
  localparam int IDX_W = idx_width(NUM_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [W-1:0]     diff_q, diff_d;
  logic             chain_q, chain_d;
  logic             mode_q, mode_d;
  logic             zero_q, zero_d;
  logic             bout_q, bout_d;
  logic             lt_q, lt_d;
  logic             eq_q, eq_d;
  logic             gt_q, gt_d;

  logic [DATA_WIDTH-1:0] a_word, b_word, d_word;
  logic                  word_bout, word_ovf;

  // Select the operand words for the current index.
  always_comb begin
    a_word = a_q[idx_q*DATA_WIDTH +: DATA_WIDTH];
    b_word = b_q[idx_q*DATA_WIDTH +: DATA_WIDTH];
  end

  word_sub #(.DATA_WIDTH(DATA_WIDTH)) u_word_sub (
    .a_w       (a_word),
    .b_w       (b_word),
    .borrow_in (chain_q),
    .d_w       (d_word),
    .borrow_out(word_bout),
    .ovf       (word_ovf)
  );

  // Next-state, operand latching and per-word result accumulation.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    diff_d  = diff_q;
    chain_d = chain_q;
    mode_d  = mode_q;
    zero_d  = zero_q;
    bout_d  = bout_q;
    lt_d    = lt_q;
    eq_d    = eq_q;
    gt_d    = gt_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d = RUN;
          idx_d   = '0;
          a_d     = bus.a;
          b_d     = bus.b;
          chain_d = bus.borrow_in;
          mode_d  = SIGNED_EN ? bus.mode_signed : MODE_UNSIGNED;
          zero_d  = 1'b1;
          bout_d  = 1'b0;
          lt_d    = 1'b0;
          eq_d    = 1'b0;
          gt_d    = 1'b0;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      RUN: begin
        diff_d[idx_q*DATA_WIDTH +: DATA_WIDTH] = d_word;
        chain_d = word_bout;
        zero_d  = zero_q & (d_word == '0);
        idx_d   = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
          bout_d  = word_bout;
          eq_d    = zero_d & ~word_bout;
          lt_d    = (mode_q == MODE_SIGNED) ? (d_word[DATA_WIDTH-1] ^ word_ovf) : word_bout;
          gt_d    = ~lt_d & ~eq_d;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and result registers; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      diff_q  <= '0;
      chain_q <= 1'b0;
      mode_q  <= MODE_UNSIGNED;
      zero_q  <= 1'b0;
      bout_q  <= 1'b0;
      lt_q    <= 1'b0;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      diff_q  <= diff_d;
      chain_q <= chain_d;
      mode_q  <= mode_d;
      zero_q  <= zero_d;
      bout_q  <= bout_d;
      lt_q    <= lt_d;
      eq_q    <= eq_d;
      gt_q    <= gt_d;
    end
  end

  assign bus.ready      = (state_q == IDLE) || (state_q == DONE);
  assign bus.done       = (state_q == DONE);
  assign bus.diff       = diff_q;
  assign bus.borrow_out = bout_q;
  assign bus.lt         = lt_q;
  assign bus.eq         = eq_q;
  assign bus.gt         = gt_q;

endmodule

// File: tb/tb_multiword_comp.sv
// Self-checking bench for multiword_comp (8-bit words, 4 words).
module tb_multiword_comp;

  localparam int DW  = 8;
  localparam int NW  = 4;
  localparam int W   = DW * NW;
  localparam int LAT = NW + 1;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         mode;
    logic [W-1:0] exp_diff;
    logic         exp_bout;
    logic         exp_lt;
    logic         exp_eq;
    logic         exp_gt;
  } vec_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  multiword_comp_if #(.DATA_WIDTH(DW), .NUM_WORDS(NW)) bus ();

  multiword_comp #(.DATA_WIDTH(DW), .NUM_WORDS(NW), .SIGNED_EN(1'b1)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Generic single-value comparison.
  task automatic checkValue(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h", name, got, want);
    end
  endtask

  // Compare all result outputs against expectations.
  task automatic checkOutput(input string name, input logic [W-1:0] ed, input logic eb,
                             input logic el, input logic ee, input logic eg);
    checkValue({name, ".diff"}, bus.diff, ed);
    checkValue({name, ".borrow_out"}, W'(bus.borrow_out), W'(eb));
    checkValue({name, ".lt"}, W'(bus.lt), W'(el));
    checkValue({name, ".eq"}, W'(bus.eq), W'(ee));
    checkValue({name, ".gt"}, W'(bus.gt), W'(eg));
  endtask

  // Drive a request; caller decides when to drop start.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic bin, input logic mode);
    bus.a           = a;
    bus.b           = b;
    bus.borrow_in   = bin;
    bus.mode_signed = mode;
    bus.start       = 1'b1;
  endtask

  // Count negedges until done, bounded; timeout counts as a failure.
  task automatic waitDone(input string name, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!bus.done && cyc < 20);
    if (!bus.done) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s timeout got no done expected done", name);
      cyc = -1;
    end
  endtask

  // Issue one operation starting at the next negedge and wait for done.
  task automatic runOp(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic bin, input logic mode, output int lat);
    @(negedge clk);
    applyStimulus(a, b, bin, mode);
    @(posedge clk);
    #1 bus.start = 1'b0;
    waitDone(name, lat);
  endtask

  // Reference from exact arithmetic on widened operands.
  task automatic refModel(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                          input logic mode, output logic [W-1:0] ed, output logic eb,
                          output logic el, output logic ee, output logic eg);
    logic [63:0]        ures;
    logic signed [63:0] sa, sb, sres;
    ures = {32'b0, a} - {32'b0, b} - {63'b0, bin};
    sa   = {{32{a[W-1]}}, a};
    sb   = {{32{b[W-1]}}, b};
    sres = sa - sb - {63'b0, bin};
    ed   = ures[W-1:0];
    eb   = ures[63];
    ee   = (ed == '0) && !eb;
    el   = mode ? (sres < 0) : eb;
    eg   = !el && !ee;
  endtask

  vec_t vecs[$];

  initial begin
    int lat;
    int dones;
    logic [W-1:0] ra, rb, ed;
    logic rbin, rmode, eb, el, ee, eg;

    checks          = 0;
    errors          = 0;
    rst_n           = 1'b0;
    bus.start       = 1'b0;
    bus.a           = '0;
    bus.b           = '0;
    bus.borrow_in   = 1'b0;
    bus.mode_signed = 1'b0;

    vecs.push_back('{32'h12345678, 32'h12345678, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{32'h00000100, 32'h00000001, 1'b0, 1'b0, 32'h000000FF, 1'b0, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{32'h00000000, 32'h00000001, 1'b0, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{32'h00000000, 32'h00000001, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{32'h80000000, 32'h00000001, 1'b0, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{32'h0000AAAA, 32'h0000AAAA, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b1, 32'h00000002, 1'b1, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{32'h7FFFFFFF, 32'h80000000, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h00000002, 1'b1, 1'b1, 1'b0, 1'b0});

    // Reset state.
    #12;
    checkOutput("reset", '0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkValue("reset.ready", W'(bus.ready), W'(1));
    checkValue("reset.done", W'(bus.done), W'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table with latency and pulse-width checks.
    foreach (vecs[i]) begin
      runOp($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].mode, lat);
      checkValue($sformatf("vec%0d.latency", i), W'(lat), W'(LAT));
      checkOutput($sformatf("vec%0d", i), vecs[i].exp_diff, vecs[i].exp_bout,
                  vecs[i].exp_lt, vecs[i].exp_eq, vecs[i].exp_gt);
      @(negedge clk);
      checkValue($sformatf("vec%0d.done_width", i), W'(bus.done), W'(0));
    end

    // Start during RUN is ignored; result belongs to the first operands.
    @(negedge clk);
    applyStimulus(32'h00001000, 32'h00000010, 1'b0, 1'b0);
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(negedge clk);
    checkValue("run.ready", W'(bus.ready), W'(0));
    applyStimulus(32'h00000000, 32'hFFFFFFFF, 1'b1, 1'b1);
    @(posedge clk);
    #1 bus.start = 1'b0;
    waitDone("ignore", lat);
    checkValue("ignore.latency", W'(lat), W'(LAT - 1));
    checkOutput("ignore", 32'h00000FF0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkValue("done.ready", W'(bus.ready), W'(1));

    // Back-to-back accept in the DONE cycle.
    applyStimulus(32'h00000005, 32'h00000007, 1'b0, 1'b0);
    @(posedge clk);
    #1 bus.start = 1'b0;
    waitDone("b2b", lat);
    checkValue("b2b.latency", W'(lat), W'(LAT));
    checkOutput("b2b", 32'hFFFFFFFE, 1'b1, 1'b1, 1'b0, 1'b0);
    dones = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    checkValue("b2b.extra_done", W'(dones), W'(0));

    // Asynchronous reset in the middle of RUN.
    @(negedge clk);
    applyStimulus(32'h11111111, 32'h00000001, 1'b0, 1'b0);
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midreset", '0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkValue("midreset.ready", W'(bus.ready), W'(1));
    checkValue("midreset.done", W'(bus.done), W'(0));
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    checkValue("midreset.no_done", W'(dones), W'(0));
    runOp("postreset", 32'h11111111, 32'h00000001, 1'b0, 1'b0, lat);
    checkValue("postreset.latency", W'(lat), W'(LAT));
    checkOutput("postreset", 32'h11111110, 1'b0, 1'b0, 1'b0, 1'b1);

    // Randomised operations against the arithmetic reference.
    for (int n = 0; n < 40; n++) begin
      ra    = $urandom;
      rb    = (n % 5 == 0) ? ra : $urandom;
      rbin  = 1'($urandom_range(1, 0));
      rmode = 1'($urandom_range(1, 0));
      if (n % 7 == 0) rb[W-1] = ~ra[W-1];
      refModel(ra, rb, rbin, rmode, ed, eb, el, ee, eg);
      runOp($sformatf("rand%0d", n), ra, rb, rbin, rmode, lat);
      checkValue($sformatf("rand%0d.latency", n), W'(lat), W'(LAT));
      checkOutput($sformatf("rand%0d", n), ed, eb, el, ee, eg);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
